// File: rtl/elapsed_timer_if.sv
// Command/status bundle between the stopwatch front panel and the elapsed timer core.
interface elapsed_timer_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        capture;
  logic        show_capture;
  logic [31:0] total_seconds_elapsed;
  logic        running;
  logic        captured_valid;
  logic        tick_1hz;

  modport master (
    output start, stop, clear, capture, show_capture,
    input  total_seconds_elapsed, running, captured_valid, tick_1hz
  );

  modport slave (
    input  start, stop, clear, capture, show_capture,
    output total_seconds_elapsed, running, captured_valid, tick_1hz
  );
endinterface

// File: rtl/elapsed_timer_ctrl.sv
// Run/pause/clear seconds counter with a one-shot breach timestamp and a
// registered display mux that feeds the 7-segment time decoder.
module elapsed_timer_ctrl #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned MAX_SECONDS = 86399
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  elapsed_timer_if.slave bus
);

  localparam int unsigned        PRESC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);
  localparam logic [31:0]        SEC_LAST   = 32'(MAX_SECONDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PRESC_W-1:0] prescaler;
  logic [31:0]        seconds;
  logic [31:0]        captured;
  logic [31:0]        display;
  logic               captured_valid;
  logic               tick;
  logic               running;
  logic               advance;
  logic               tick_due;
  logic               capture_take;

  // Next state and per-cycle enables; stop outranks start so a stop blocks any start.
  always_comb begin
    state_next   = state;
    advance      = 1'b0;
    tick_due     = 1'b0;
    capture_take = 1'b0;
    if (bus.clear) begin
      state_next = IDLE;
    end else if (bus.stop) begin
      if (state == RUNNING) begin
        state_next = PAUSED;
      end else begin
        state_next = state;
      end
    end else if (bus.start) begin
      case (state)
        IDLE:    state_next = RUNNING;
        PAUSED:  state_next = RUNNING;
        RUNNING: state_next = RUNNING;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
    advance      = (state == RUNNING) && !bus.stop && !bus.clear;
    tick_due     = advance && (prescaler == PRESC_LAST);
    capture_take = bus.capture && !captured_valid && (state != IDLE) && !bus.clear;
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prescaler, seconds counter, timestamp latch and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      prescaler      <= {PRESC_W{1'b0}};
      seconds        <= 32'd0;
      captured       <= 32'd0;
      captured_valid <= 1'b0;
      tick           <= 1'b0;
      running        <= 1'b0;
      display        <= 32'd0;
    end else begin
      running <= (state_next == RUNNING);
      if (bus.clear) begin
        prescaler      <= {PRESC_W{1'b0}};
        seconds        <= 32'd0;
        captured       <= 32'd0;
        captured_valid <= 1'b0;
        tick           <= 1'b0;
      end else begin
        tick <= tick_due;
        if (advance) begin
          prescaler <= tick_due ? {PRESC_W{1'b0}} : prescaler + PRESC_W'(1);
        end
        if (tick_due) begin
          seconds <= (seconds == SEC_LAST) ? 32'd0 : seconds + 32'd1;
        end
        // Timestamp takes the value seen this cycle, before any coincident increment.
        if (capture_take) begin
          captured       <= seconds;
          captured_valid <= 1'b1;
        end
      end
      display <= (bus.show_capture && captured_valid) ? captured : seconds;
    end
  end

  assign bus.total_seconds_elapsed = display;
  assign bus.running               = running;
  assign bus.captured_valid        = captured_valid;
  assign bus.tick_1hz              = tick;

endmodule
